priority_encoder: RTL and testbench

- Parameterised MSB-first priority encoder; default is 8 request lines encoded to a 3-bit index.
- Provides a combinational result path (out, valid) for immediate use.
- Provides a registered copy of the result (out_q, valid_q) for timing-closed consumers.
- Sits between request-gathering logic (interrupt or arbitration lines) and downstream index consumers.

---
 rtl/priority_encoder.sv | 84 ++++++++
 tb/tb_priority_encoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/priority_encoder.sv
// -----------------------------------------------------------------------------
// Module  : priority_encoder
// Brief   : MSB-first priority encoder with combinational and registered result.
//           Define PRIORITY_ENCODER_ONEHOT_EN to add one-hot grant/grant_q ports.
// Rev     : 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

module priority_encoder #(
   parameter int WIDTH = 8,
   parameter int OUT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] in,
   output logic [OUT_W-1:0] out,
   output logic             valid,
   output logic [OUT_W-1:0] out_q,
`ifdef PRIORITY_ENCODER_ONEHOT_EN
   output logic [WIDTH-1:0] grant,
   output logic [WIDTH-1:0] grant_q,
`endif
   output logic             valid_q
);

   logic [OUT_W-1:0] w_out;
   logic             w_valid;
   logic [OUT_W-1:0] r_out_q;
   logic             r_valid_q;

   // Ascending scan: the last set bit seen is the highest, so it wins.
   always_comb begin
      w_out   = '0;
      w_valid = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (in[i]) begin
            w_out   = OUT_W'(i);
            w_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_q   <= '0;
         r_valid_q <= 1'b0;
      end else if (en) begin
         r_out_q   <= w_out;
         r_valid_q <= w_valid;
      end
   end

   assign out     = w_out;
   assign valid   = w_valid;
   assign out_q   = r_out_q;
   assign valid_q = r_valid_q;

`ifdef PRIORITY_ENCODER_ONEHOT_EN
   logic [WIDTH-1:0] w_grant;
   logic [WIDTH-1:0] r_grant_q;

   always_comb begin
      w_grant = '0;
      if (w_valid) begin
         w_grant[w_out] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant_q <= '0;
      end else if (en) begin
         r_grant_q <= w_grant;
      end
   end

   assign grant   = w_grant;
   assign grant_q = r_grant_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_priority_encoder.sv
// -----------------------------------------------------------------------------
// Module  : tb_priority_encoder
// Brief   : Directed-vector self-checking bench for priority_encoder.
// Rev     : 1.0  initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_priority_encoder;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] in;
   logic [2:0] out;
   logic       valid;
   logic [2:0] out_q;
   logic       valid_q;
   logic [4:0] in5;
   logic [2:0] out5;
   logic       valid5;
   logic [2:0] out5_q;
   logic       valid5_q;
`ifdef PRIORITY_ENCODER_ONEHOT_EN
   logic [7:0] grant;
   logic [7:0] grant_q;
   logic [4:0] grant5;
   logic [4:0] grant5_q;
`endif

   int n_checks = 0;
   int n_errors = 0;

   priority_encoder #(.WIDTH(8)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .in      (in),
      .out     (out),
      .valid   (valid),
      .out_q   (out_q),
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      .grant   (grant),
      .grant_q (grant_q),
`endif
      .valid_q (valid_q)
   );

   priority_encoder #(.WIDTH(5)) u_dut5 (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .in      (in5),
      .out     (out5),
      .valid   (valid5),
      .out_q   (out5_q),
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      .grant   (grant5),
      .grant_q (grant5_q),
`endif
      .valid_q (valid5_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: scan downward from the MSB, first set bit is the answer.
   function automatic logic [3:0] ref_enc(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) return {1'b1, 3'(i)};
      end
      return 4'd0;
   endfunction

   logic [7:0] dir_in    [6] = '{8'h00, 8'h01, 8'h80, 8'h2C, 8'hFF, 8'h06};
   logic [2:0] dir_out   [6] = '{3'd0,  3'd0,  3'd7,  3'd5,  3'd7,  3'd2};
   logic       dir_valid [6] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b1,  1'b1};

   initial begin
      logic [3:0] r;
      rst_n = 1'b0;
      en    = 1'b0;
      in    = 8'h00;
      in5   = 5'h00;
      #1;
      check("reset_out_q", 32'(out_q), 32'd0);
      check("reset_valid_q", 32'(valid_q), 32'd0);

      // Directed combinational vectors
      for (int k = 0; k < 6; k++) begin
         in = dir_in[k];
         #1;
         check($sformatf("dir_out_%02h", dir_in[k]), 32'(out), 32'(dir_out[k]));
         check($sformatf("dir_valid_%02h", dir_in[k]), 32'(valid), 32'(dir_valid[k]));
      end

      // Full 256-value sweep
      for (int k = 0; k < 256; k++) begin
         in = 8'(k);
         #1;
         r = ref_enc(in);
         check($sformatf("sweep_out_%02h", in), 32'(out), 32'(r[2:0]));
         check($sformatf("sweep_valid_%02h", in), 32'(valid), 32'(r[3]));
      end

      // Random vectors every 10 ns
      for (int k = 0; k < 8; k++) begin
         in = 8'($urandom_range(0, 255));
         #10;
         r = ref_enc(in);
         check($sformatf("rand_out_%02h", in), 32'(out), 32'(r[2:0]));
         check($sformatf("rand_valid_%02h", in), 32'(valid), 32'(|in));
      end

      // Non-power-of-two width
      in5 = 5'b10000; #1;
      check("w5_out_10", 32'(out5), 32'd4);
      in5 = 5'b11111; #1;
      check("w5_out_1f", 32'(out5), 32'd4);
      in5 = 5'b00110; #1;
      check("w5_out_06", 32'(out5), 32'd2);
      check("w5_valid_06", 32'(valid5), 32'd1);

      // en is ignored while reset is held
      @(negedge clk);
      en = 1'b1;
      in = 8'h80;
      @(posedge clk); #1;
      check("rst_hold_out_q", 32'(out_q), 32'd0);
      check("rst_hold_valid_q", 32'(valid_q), 32'd0);

      // First capture after release
      @(negedge clk);
      rst_n = 1'b1;
      in    = 8'h24;
      @(posedge clk); #1;
      check("reg_out_q_24", 32'(out_q), 32'd5);
      check("reg_valid_q_24", 32'(valid_q), 32'd1);

      @(negedge clk);
      en = 1'b0;
      in = 8'h01;
      @(posedge clk); #1;
      check("hold_out_q", 32'(out_q), 32'd5);
      check("hold_valid_q", 32'(valid_q), 32'd1);
      check("hold_comb_out", 32'(out), 32'd0);

      @(negedge clk);
      en = 1'b1;
      in = 8'h00;
      @(posedge clk); #1;
      check("zero_out_q", 32'(out_q), 32'd0);
      check("zero_valid_q", 32'(valid_q), 32'd0);

`ifdef PRIORITY_ENCODER_ONEHOT_EN
      @(negedge clk);
      in = 8'b0101_0000;
      #1;
      check("grant_50", 32'(grant), 32'h40);
      check("grant_q_pre", 32'(grant_q), 32'h00);
      @(posedge clk); #1;
      check("grant_q_50", 32'(grant_q), 32'h40);
      @(negedge clk);
      in = 8'h00;
      #1;
      check("grant_0", 32'(grant), 32'h00);
      check("grant_q_held", 32'(grant_q), 32'h40);
      @(posedge clk); #1;
      check("grant_q_0", 32'(grant_q), 32'h00);
`endif

      // Asynchronous reset mid-cycle
      @(negedge clk);
      en = 1'b1;
      in = 8'h20;
      @(posedge clk); #1;
      check("pre_arst_out_q", 32'(out_q), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_q", 32'(out_q), 32'd0);
      check("arst_valid_q", 32'(valid_q), 32'd0);
      check("arst_comb_out", 32'(out), 32'd5);
      check("arst_comb_valid", 32'(valid), 32'd1);
`ifdef PRIORITY_ENCODER_ONEHOT_EN
      check("arst_grant_q", 32'(grant_q), 32'h00);
`endif
      in = 8'h03;
      #1;
      check("arst_comb_track", 32'(out), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
